gpio_chain_loader: RTL and testbench

- Sequencer for the GPIO pad-configuration serial chain: NO_PAD shift stages, PAD_CTRL_BITS bits each, all clocked by serial_clock.
- Holds a per-pad configuration shadow array and a per-pad hold-violation skip mask, both writable by the host.
- On start, shifts the whole array into the chain, farthest pad first, then pulses serial_load.
- A pad flagged in the skip mask is shifted one bit short. This compensates for a stage that captures an extra bit because of clock-chain hold violation, so downstream pads still land intact.

---
 rtl/gpio_chain_loader.sv | 192 +++++++++++++++++++
 tb/tb_gpio_chain_loader.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_chain_loader.sv
// rtl/gpio_chain_loader.sv - GPIO pad-configuration serial chain sequencer
// Shifts a per-pad shadow array into the pad chain (farthest pad first), then strobes serial_load.
module gpio_chain_loader #(
    parameter int                       NO_PAD        = 38,
    parameter int                       PAD_CTRL_BITS = 13,
    parameter logic [PAD_CTRL_BITS-1:0] DEF_CFG       = 13'h1800,
    parameter logic [NO_PAD-1:0]        DEF_SKIP      = '0,
    parameter int                       LOAD_CYCLES   = 2
) (
    input  logic                     serial_clock,
    input  logic                     resetn,
    input  logic                     cfg_we,
    input  logic [5:0]               cfg_addr,
    input  logic [PAD_CTRL_BITS-1:0] cfg_wdata,
    output logic [PAD_CTRL_BITS-1:0] cfg_rdata,
    input  logic                     skip_we,
    input  logic [NO_PAD-1:0]        skip_wdata,
    output logic [NO_PAD-1:0]        skip_mask,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err,
    output logic                     shift_enb,
    output logic                     serial_data,
    output logic                     serial_load
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_LOAD
    } state_t;

    localparam logic [3:0] B_FULL = 4'(PAD_CTRL_BITS - 1);
    localparam logic [3:0] B_SKIP = 4'(PAD_CTRL_BITS - 2);
    localparam logic [5:0] P_LAST = 6'(NO_PAD - 1);
    localparam logic [3:0] L_END  = 4'(LOAD_CYCLES);
    localparam logic [6:0] NP7    = 7'(NO_PAD);

    logic [PAD_CTRL_BITS-1:0] shadow_q [NO_PAD];
    logic [PAD_CTRL_BITS-1:0] shadow_d [NO_PAD];
    logic [NO_PAD-1:0]        skip_q, skip_d;
    state_t                   state_q, state_d;
    logic [5:0]               pad_q, pad_d;
    logic [3:0]               bit_q, bit_d;
    logic [3:0]               load_q, load_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     cfg_err_q, cfg_err_d;
    logic                     shift_enb_q, shift_enb_d;
    logic                     serial_data_q, serial_data_d;
    logic                     serial_load_q, serial_load_d;
    logic                     addr_ok;
    logic [5:0]               pad_dec;

    assign addr_ok = ({1'b0, cfg_addr} < NP7);
    assign pad_dec = pad_q - 6'd1;

    always_comb begin
        cfg_rdata = '0;
        if (addr_ok) begin
            cfg_rdata = shadow_q[cfg_addr];
        end
    end

    always_comb begin
        shadow_d      = shadow_q;
        skip_d        = skip_q;
        state_d       = state_q;
        pad_d         = pad_q;
        bit_d         = bit_q;
        load_d        = load_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        cfg_err_d     = 1'b0;
        shift_enb_d   = shift_enb_q;
        serial_data_d = serial_data_q;
        serial_load_d = serial_load_q;

        // The chain reads the shadow live while shifting, so writes are refused when busy.
        if (cfg_we) begin
            if (busy_q || !addr_ok) begin
                cfg_err_d = 1'b1;
            end else begin
                shadow_d[cfg_addr] = cfg_wdata;
            end
        end
        if (skip_we) begin
            if (busy_q) begin
                cfg_err_d = 1'b1;
            end else begin
                skip_d = skip_wdata;
            end
        end

        case (state_q)
            ST_IDLE: begin
                shift_enb_d   = 1'b0;
                serial_load_d = 1'b0;
                busy_d        = 1'b0;
                if (start) begin
                    state_d = ST_SHIFT;
                    pad_d   = P_LAST;
                    bit_d   = skip_d[NO_PAD-1] ? B_SKIP : B_FULL;
                    busy_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                shift_enb_d   = 1'b1;
                serial_data_d = shadow_q[pad_q][bit_q];
                if (bit_q != 4'd0) begin
                    bit_d = bit_q - 4'd1;
                end else if (pad_q != 6'd0) begin
                    pad_d = pad_dec;
                    bit_d = skip_q[pad_dec] ? B_SKIP : B_FULL;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                shift_enb_d   = 1'b0;
                serial_load_d = 1'b0;
                load_d        = 4'd0;
                state_d       = ST_LOAD;
            end
            default: begin
                // One extra LOAD cycle drops serial_load so done lines up with busy falling.
                shift_enb_d = 1'b0;
                if (load_q == L_END) begin
                    serial_load_d = 1'b0;
                    done_d        = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    serial_load_d = 1'b1;
                    load_d        = load_q + 4'd1;
                end
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d       = ST_IDLE;
            shift_enb_d   = 1'b0;
            serial_load_d = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b0;
        end
    end

    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NO_PAD; i++) begin
                shadow_q[i] <= DEF_CFG;
            end
            skip_q        <= DEF_SKIP;
            state_q       <= ST_IDLE;
            pad_q         <= '0;
            bit_q         <= '0;
            load_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
            shift_enb_q   <= 1'b0;
            serial_data_q <= 1'b0;
            serial_load_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            skip_q        <= skip_d;
            state_q       <= state_d;
            pad_q         <= pad_d;
            bit_q         <= bit_d;
            load_q        <= load_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cfg_err_q     <= cfg_err_d;
            shift_enb_q   <= shift_enb_d;
            serial_data_q <= serial_data_d;
            serial_load_q <= serial_load_d;
        end
    end

    assign skip_mask   = skip_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;
    assign shift_enb   = shift_enb_q;
    assign serial_data = serial_data_q;
    assign serial_load = serial_load_q;

endmodule

// File: tb/tb_gpio_chain_loader.sv
// tb/tb_gpio_chain_loader.sv - bench for gpio_chain_loader
// Emulates the pad chain (with late-clocked stages) and compares against a per-pad bit-list model.
module tb_gpio_chain_loader;

    localparam int NP = 38;
    localparam int PB = 13;
    localparam logic [PB-1:0] DEF = 13'h1800;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [5:0]    cfg_addr = '0;
    logic [PB-1:0] cfg_wdata = '0;
    logic [PB-1:0] cfg_rdata;
    logic          skip_we = 1'b0;
    logic [NP-1:0] skip_wdata = '0;
    logic [NP-1:0] skip_mask;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, cfg_err, shift_enb, serial_data, serial_load;

    always #5 clk = ~clk;

    gpio_chain_loader dut (
        .serial_clock(clk),
        .resetn      (rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_rdata   (cfg_rdata),
        .skip_we     (skip_we),
        .skip_wdata  (skip_wdata),
        .skip_mask   (skip_mask),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .shift_enb   (shift_enb),
        .serial_data (serial_data),
        .serial_load (serial_load)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Host-side model of what the shadow and skip mask should hold.
    logic [PB-1:0] sh_m [NP];
    logic [NP-1:0] skip_m;

    // Pad chain: late-clocked stages let their MSB flop race through from bit 11.
    logic [PB-1:0] chain [NP];
    logic [PB-1:0] latched [NP];
    always @(posedge clk) begin
        logic [PB-1:0] nxt [NP];
        if (shift_enb) begin
            for (int k = 0; k < NP; k++) begin
                logic in_b;
                in_b = (k == 0) ? serial_data : chain[k-1][PB-1];
                nxt[k] = skip_m[k] ? {chain[k][PB-3], chain[k][PB-3:0], in_b}
                                   : {chain[k][PB-2:0], in_b};
            end
            for (int k = 0; k < NP; k++) chain[k] = nxt[k];
        end
        if (serial_load) begin
            for (int k = 0; k < NP; k++) latched[k] = chain[k];
        end
    end

    bit mon_en = 1'b0;
    int cyc = 0;
    int n_se, first_se, last_se, n_ld, first_ld, last_ld, n_done, done_cyc;
    bit done_busy;
    bit stream[$];
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (shift_enb) begin
                n_se++;
                if (first_se < 0) first_se = cyc;
                last_se = cyc;
                stream.push_back(serial_data);
            end
            if (serial_load) begin
                n_ld++;
                if (first_ld < 0) first_ld = cyc;
                last_ld = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc  = cyc;
                done_busy = busy;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bits the chain must receive: pads from farthest down, each MSB first, skipped pads minus their MSB.
    function automatic int stream_bad();
        bit exp_q[$];
        int bad = 0;
        for (int p = NP - 1; p >= 0; p--)
            for (int b = (skip_m[p] ? PB - 2 : PB - 1); b >= 0; b--)
                exp_q.push_back(sh_m[p][b]);
        if (exp_q.size() != stream.size()) return 9999;
        foreach (exp_q[i]) if (exp_q[i] !== stream[i]) bad++;
        return bad;
    endfunction

    task automatic write_cfg(input logic [5:0] a, input logic [PB-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        if (a < NP) sh_m[a] = d;
    endtask

    task automatic write_skip(input logic [NP-1:0] v);
        skip_we = 1'b1; skip_wdata = v;
        tick();
        skip_we = 1'b0;
        skip_m = v;
    endtask

    task automatic begin_seq(input bit wr, input logic [5:0] a, input logic [PB-1:0] d);
        n_se = 0; n_ld = 0; n_done = 0; first_se = -1; last_se = -1;
        first_ld = -1; last_ld = -1; done_cyc = -1; done_busy = 1'b1;
        stream.delete();
        mon_en = 1'b1;
        if (wr) begin
            cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d; sh_m[a] = d;
        end
        start = 1'b1;
        tick();
        start = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            tick();
            if (n_done > 0) begin
                to = 1'b0;
                break;
            end
        end
        tick(); tick();
        mon_en = 1'b0;
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < NP; k++) sh_m[k] = DEF;
        skip_m = '0;
        chk_cnt++;
        if ({busy, done, cfg_err, shift_enb, serial_data, serial_load} !== 6'b0)
            $display("FAIL reset_outputs got=%b exp=000000", {busy, done, cfg_err, shift_enb, serial_data, serial_load});
        else pass_cnt++;
        chk_cnt++;
        if (skip_mask !== '0) $display("FAIL reset_skip got=%h exp=0", skip_mask);
        else pass_cnt++;
        for (int k = 0; k < NP; k++) begin
            cfg_addr = 6'(k); #1;
            if (cfg_rdata !== DEF) bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL reset_shadow bad_words=%0d exp=0", bad);
        else pass_cnt++;
        cfg_addr = 6'd40; #1;
        chk_cnt++;
        if (cfg_rdata !== '0) $display("FAIL rdata_oob got=%h exp=0", cfg_rdata);
        else pass_cnt++;
    endtask

    task automatic test_default_load();
        bit to;
        int bad = 0;
        begin_seq(1'b0, 6'd0, '0);
        wait_done(to);
        chk_cnt++;
        if (to) $display("FAIL default_timeout got=timeout exp=done"); else pass_cnt++;
        chk_cnt++;
        if (n_se != 494 || last_se - first_se + 1 != 494)
            $display("FAIL default_shift got=%0d span=%0d exp=494", n_se, last_se - first_se + 1);
        else pass_cnt++;
        chk_cnt++;
        if (first_ld - last_se != 2) $display("FAIL default_gap got=%0d exp=1", first_ld - last_se - 1);
        else pass_cnt++;
        chk_cnt++;
        if (n_ld != 2 || last_ld - first_ld + 1 != 2) $display("FAIL default_load got=%0d exp=2", n_ld);
        else pass_cnt++;
        chk_cnt++;
        if (n_done != 1 || done_cyc != last_ld + 1 || done_busy !== 1'b0)
            $display("FAIL default_done got=n%0d@%0d busy=%b exp=n1@%0d busy=0", n_done, done_cyc, done_busy, last_ld + 1);
        else pass_cnt++;
        chk_cnt++;
        if (stream_bad() != 0) $display("FAIL default_stream got=%0d_bad exp=0", stream_bad());
        else pass_cnt++;
        for (int k = 0; k < NP; k++) if (latched[k] !== DEF) bad++;
        chk_cnt++;
        if (bad != 0) $display("FAIL default_chain bad_stages=%0d exp=0", bad);
        else pass_cnt++;
    endtask

    task automatic test_skip_skew();
        bit to;
        int bad = 0;
        write_skip(38'h12_1000_0000);
        chk_cnt++;
        if (skip_mask !== 38'h12_1000_0000) $display("FAIL skip_write got=%h exp=1210000000", skip_mask);
        else pass_cnt++;
        begin_seq(1'b0, 6'd0, '0);
        wait_done(to);
        chk_cnt++;
        if (to || n_se != 491 || n_done != 1) $display("FAIL skip_shift got=%0d done=%0d exp=491 done=1", n_se, n_done);
        else pass_cnt++;
        chk_cnt++;
        if (stream_bad() != 0) $display("FAIL skip_stream got=%0d_bad exp=0", stream_bad());
        else pass_cnt++;
        for (int k = 0; k < NP; k++) if (latched[k] !== DEF) bad++;
        chk_cnt++;
        if (bad != 0) $display("FAIL skip_chain bad_stages=%0d exp=0", bad);
        else pass_cnt++;
        write_skip('0);
    endtask

    task automatic test_pattern();
        bit to;
        int bad = 0;
        int bad_rd = 0;
        for (int k = 0; k < NP; k++) write_cfg(6'(k), 13'(k) | 13'h1000);
        for (int k = 0; k < NP; k++) begin
            cfg_addr = 6'(k); #1;
            if (cfg_rdata !== (13'(k) | 13'h1000)) bad_rd++;
        end
        chk_cnt++;
        if (bad_rd != 0) $display("FAIL pattern_readback bad_words=%0d exp=0", bad_rd);
        else pass_cnt++;
        begin_seq(1'b0, 6'd0, '0);
        wait_done(to);
        for (int k = 0; k < NP; k++) if (latched[k] !== (13'(k) | 13'h1000)) bad++;
        chk_cnt++;
        if (to || bad != 0) $display("FAIL pattern_chain bad_stages=%0d exp=0", bad);
        else pass_cnt++;
    endtask

    task automatic test_busy_write();
        bit to;
        logic [PB-1:0] old5;
        old5 = sh_m[5];
        begin_seq(1'b0, 6'd0, '0);
        for (int i = 0; i < 300 && n_se < 100; i++) tick();
        cfg_we = 1'b1; cfg_addr = 6'd5; cfg_wdata = ~old5; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        chk_cnt++;
        if (cfg_err !== 1'b1) $display("FAIL busy_cfg_err got=%b exp=1", cfg_err); else pass_cnt++;
        skip_we = 1'b1; skip_wdata = '1;
        tick();
        skip_we = 1'b0;
        chk_cnt++;
        if (cfg_err !== 1'b1) $display("FAIL busy_skip_err got=%b exp=1", cfg_err); else pass_cnt++;
        tick();
        chk_cnt++;
        if (cfg_err !== 1'b0) $display("FAIL err_pulse got=%b exp=0", cfg_err); else pass_cnt++;
        wait_done(to);
        chk_cnt++;
        if (to || n_se != 494 || n_done != 1) $display("FAIL busy_seq got=%0d done=%0d exp=494 done=1", n_se, n_done);
        else pass_cnt++;
        cfg_addr = 6'd5; #1;
        chk_cnt++;
        if (cfg_rdata !== old5 || skip_mask !== skip_m)
            $display("FAIL busy_dropped got=%h/%h exp=%h/%h", cfg_rdata, skip_mask, old5, skip_m);
        else pass_cnt++;
        write_cfg(6'd40, 13'h1fff);
        chk_cnt++;
        if (cfg_err !== 1'b1) $display("FAIL oob_err got=%b exp=1", cfg_err); else pass_cnt++;
        write_cfg(6'd3, 13'h0aaa);
        chk_cnt++;
        if (cfg_err !== 1'b0) $display("FAIL good_write_err got=%b exp=0", cfg_err); else pass_cnt++;
    endtask

    task automatic test_abort();
        bit to;
        begin_seq(1'b0, 6'd0, '0);
        for (int i = 0; i < 400 && n_se < 200; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_cnt++;
        if (shift_enb !== 1'b0 || busy !== 1'b0) $display("FAIL abort_stop got=se%b busy%b exp=0", shift_enb, busy);
        else pass_cnt++;
        for (int i = 0; i < 20; i++) tick();
        mon_en = 1'b0;
        chk_cnt++;
        if (n_ld != 0 || n_done != 0) $display("FAIL abort_noload got=ld%0d done%0d exp=0", n_ld, n_done);
        else pass_cnt++;
        abort = 1'b1; tick(); abort = 1'b0;
        begin_seq(1'b0, 6'd0, '0);
        wait_done(to);
        chk_cnt++;
        if (to || n_se != 494 || n_done != 1 || stream_bad() != 0)
            $display("FAIL abort_restart got=%0d done=%0d exp=494 done=1", n_se, n_done);
        else pass_cnt++;
    endtask

    task automatic test_random();
        bit to;
        logic [PB-1:0] d;
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < NP; k++) write_cfg(6'(k), 13'($urandom));
            write_skip(NP'({$urandom(), $urandom()}));
            d = 13'($urandom);
            begin_seq(1'b1, 6'(NP - 1), d);
            wait_done(to);
            chk_cnt++;
            if (to || n_se != NP * PB - $countones(skip_m) || n_done != 1)
                $display("FAIL random_len it=%0d got=%0d exp=%0d", it, n_se, NP * PB - $countones(skip_m));
            else pass_cnt++;
            chk_cnt++;
            if (stream_bad() != 0) $display("FAIL random_stream it=%0d got=%0d_bad exp=0", it, stream_bad());
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int bad = 0;
        begin_seq(1'b0, 6'd0, '0);
        to = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            tick();
            if (serial_load) begin
                to = 1'b0;
                break;
            end
        end
        mon_en = 1'b0;
        chk_cnt++;
        if (to || busy !== 1'b1) $display("FAIL rstmid_reach got=busy%b exp=load_busy", busy); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({serial_load, busy, done, shift_enb} !== 4'b0)
            $display("FAIL rstmid_async got=%b exp=0000", {serial_load, busy, done, shift_enb});
        else pass_cnt++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < NP; k++) sh_m[k] = DEF;
        skip_m = '0;
        for (int k = 0; k < NP; k++) begin
            cfg_addr = 6'(k); #1;
            if (cfg_rdata !== DEF) bad++;
        end
        chk_cnt++;
        if (bad != 0 || skip_mask !== '0) $display("FAIL rstmid_shadow bad_words=%0d skip=%h exp=0", bad, skip_mask);
        else pass_cnt++;
    endtask

    initial begin
        for (int k = 0; k < NP; k++) begin
            chain[k] = '0;
            latched[k] = '0;
            sh_m[k] = DEF;
        end
        skip_m = '0;
        test_reset();
        test_default_load();
        test_skip_skew();
        test_pattern();
        test_busy_write();
        test_abort();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
